// File: rtl/core_pkg.sv
// core_pkg: shared writeback-path types.
//   XLEN      data width
//   NREG      architectural register count
//   regaddr_t register address (x0..x31)
//   wb_req_t  one writeback request {rd, data}
package core_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;

  typedef logic [4:0] regaddr_t;

  typedef struct packed {
    regaddr_t        rd;
    logic [XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: writeback arbiter bus bundle.
//   ALU result   : aluValid/aluRd/aluData (no backpressure)
//   LSU result   : lsuValid/lsuReady/lsuRd/lsuData (valid/ready)
//   issue        : issueValid/issueRd (marks destination busy)
//   scoreboard   : busy
//   regfile port : writeRegMem/rd/dataIn
// slave = arbiter side, master = pipeline/regfile side.
interface wb_arbiter_if;
  import core_pkg::*;

  logic            aluValid;
  regaddr_t        aluRd;
  logic [XLEN-1:0] aluData;
  logic            lsuValid;
  logic            lsuReady;
  regaddr_t        lsuRd;
  logic [XLEN-1:0] lsuData;
  logic            issueValid;
  regaddr_t        issueRd;
  logic [NREG-1:0] busy;
  logic            writeRegMem;
  regaddr_t        rd;
  logic [XLEN-1:0] dataIn;

  modport slave (
    input  aluValid, aluRd, aluData, lsuValid, lsuRd, lsuData, issueValid, issueRd,
    output lsuReady, busy, writeRegMem, rd, dataIn
  );

  modport master (
    output aluValid, aluRd, aluData, lsuValid, lsuRd, lsuData, issueValid, issueRd,
    input  lsuReady, busy, writeRegMem, rd, dataIn
  );
endinterface

// File: rtl/wb_skid.sv
// wb_skid: one-entry holding buffer for a writeback request.
//   Clock, nReset : clock, async active-low reset
//   load          : capture din, entry becomes full
//   drain         : release the entry (dout consumed this cycle)
//   din / dout    : request in / held request
//   full          : entry occupied
// load and drain are never asserted together by the arbiter
// (load needs empty, drain needs full); load takes precedence anyway.
module wb_skid
  import core_pkg::*;
(
  input  logic    Clock,
  input  logic    nReset,
  input  logic    load,
  input  logic    drain,
  input  wb_req_t din,
  output logic    full,
  output wb_req_t dout
);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      full <= 1'b0;
      dout <= '0;
    end else if (load) begin
      full <= 1'b1;
      dout <= din;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU and long-latency (LSU) results onto the single
// register-file write port and keeps the busy scoreboard.
//   Clock, nReset : clock, async active-low reset
//   bus           : wb_arbiter_if.slave (ALU, LSU, issue, busy, regfile write)
// Priority into the output register: ALU > skid entry > new LSU transfer.
// An LSU transfer that collides with the ALU parks in the skid.
module wb_arbiter
  import core_pkg::*;
#(
  parameter int XLEN = core_pkg::XLEN,
  parameter int NREG = core_pkg::NREG
) (
  input  logic         Clock,
  input  logic         nReset,
  wb_arbiter_if.slave  bus
);

  logic            skidFull;
  wb_req_t         skidReq;
  wb_req_t         lsuReq;
  logic            lsuXfer;
  logic            skidLoad;
  logic            skidDrain;

  wb_req_t         sel;
  logic            selValid;
  logic            selLsu;
  logic [NREG-1:0] setMask;
  logic [NREG-1:0] clrMask;

  logic            wrQ;
  regaddr_t        rdQ;
  logic [XLEN-1:0] dataQ;
  logic [NREG-1:0] busyQ;

  // Ready depends on state only, so the LSU never sees a comb loop.
  assign bus.lsuReady = !skidFull;
  assign lsuXfer      = bus.lsuValid && !skidFull;
  assign skidLoad     = lsuXfer && bus.aluValid;
  assign skidDrain    = skidFull && !bus.aluValid;

  always_comb begin
    lsuReq.rd   = bus.lsuRd;
    lsuReq.data = bus.lsuData;
  end

  wb_skid u_skid (
    .Clock  (Clock),
    .nReset (nReset),
    .load   (skidLoad),
    .drain  (skidDrain),
    .din    (lsuReq),
    .full   (skidFull),
    .dout   (skidReq)
  );

  always_comb begin
    sel      = '0;
    selValid = 1'b0;
    selLsu   = 1'b0;
    if (bus.aluValid) begin
      sel.rd   = bus.aluRd;
      sel.data = bus.aluData;
      selValid = 1'b1;
    end else if (skidFull) begin
      sel      = skidReq;
      selValid = 1'b1;
      selLsu   = 1'b1;
    end else if (lsuXfer) begin
      sel      = lsuReq;
      selValid = 1'b1;
      selLsu   = 1'b1;
    end
  end

  // Clear is applied before set so a same-cycle issue to the same register wins.
  always_comb begin
    setMask = '0;
    clrMask = '0;
    if (bus.issueValid && bus.issueRd != '0) setMask[bus.issueRd] = 1'b1;
    if (selValid && selLsu && sel.rd != '0)  clrMask[sel.rd]      = 1'b1;
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      wrQ   <= 1'b0;
      rdQ   <= '0;
      dataQ <= '0;
      busyQ <= '0;
    end else begin
      // x0 writes complete the handshake but never strobe the regfile.
      wrQ <= selValid && (sel.rd != '0);
      if (selValid) begin
        rdQ   <= sel.rd;
        dataQ <= sel.data;
      end
      busyQ <= (busyQ & ~clrMask) | setMask;
    end
  end

  assign bus.writeRegMem = wrQ;
  assign bus.rd          = rdQ;
  assign bus.dataIn      = dataQ;
  assign bus.busy        = busyQ;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  import core_pkg::*;

  logic clk = 1'b0;
  logic nReset = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter_if bus ();

  wb_arbiter dut (
    .Clock  (clk),
    .nReset (nReset),
    .bus    (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic iv, input logic [4:0] ird);
    bus.aluValid   = av;
    bus.aluRd      = ard;
    bus.aluData    = ad;
    bus.lsuValid   = lv;
    bus.lsuRd      = lrd;
    bus.lsuData    = ld;
    bus.issueValid = iv;
    bus.issueRd    = ird;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  task automatic do_reset();
    idle();
    nReset = 1'b0;
    repeat (2) @(negedge clk);
    nReset = 1'b1;
  endtask

  // Reference model: accepted LSU results form an in-order queue; each cycle
  // the ALU wins the port, otherwise the oldest queued LSU result is written.
  // The LSU is ready only when nothing is left waiting.
  logic        m_wr;
  logic [4:0]  m_rd;
  logic [31:0] m_d;
  logic [31:0] m_busy;
  logic [36:0] mq[$];

  task automatic mstep(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic iv, input logic [4:0] ird, output logic acc);
    logic        ready;
    logic [36:0] e;
    ready = (mq.size() == 0);
    chk("rand_lsuReady", {63'd0, bus.lsuReady}, {63'd0, ready});
    acc = lv && ready;
    if (acc) mq.push_back({lrd, ld});
    if (av) begin
      m_wr = (ard != 0); m_rd = ard; m_d = ad;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_wr = (e[36:32] != 0); m_rd = e[36:32]; m_d = e[31:0];
      if (e[36:32] != 0) m_busy[e[36:32]] = 1'b0;
    end else begin
      m_wr = 1'b0;
    end
    if (iv && ird != 0) m_busy[ird] = 1'b1;
  endtask

  typedef struct {
    logic        av;  logic [4:0] ard; logic [31:0] ad;
    logic        lv;  logic [4:0] lrd; logic [31:0] ld;
    logic        iv;  logic [4:0] ird;
    logic        rdy;
    logic        wr;  logic [4:0] rd;  logic [31:0] d;
    logic [31:0] busy;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic        lpend, acc, av, iv;
    logic [4:0]  lrd, ard, ird;
    logic [31:0] ld, ad;

    // issue/alu/lsu sequence starting from reset; rdy sampled at drive time,
    // the rest after the following edge
    //          av  ard    ad       lv  lrd    ld       iv  ird    rdy wr  rd     d        busy
    tbl[0]  = '{0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    1, 5'd7,  1,  0, 5'd0,  32'h0,    32'h0000_0080};
    tbl[1]  = '{0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    0, 5'd0,  1,  0, 5'd0,  32'h0,    32'h0000_0080};
    tbl[2]  = '{1, 5'd5,  32'h1234, 0, 5'd0,  32'h0,    0, 5'd0,  1,  1, 5'd5,  32'h1234, 32'h0000_0080};
    tbl[3]  = '{1, 5'd3,  32'hA,    1, 5'd7,  32'hB,    0, 5'd0,  1,  1, 5'd3,  32'hA,    32'h0000_0080};
    tbl[4]  = '{0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    0, 5'd0,  0,  1, 5'd7,  32'hB,    32'h0};
    tbl[5]  = '{0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    0, 5'd0,  1,  0, 5'd0,  32'h0,    32'h0};
    tbl[6]  = '{1, 5'd0,  32'h55,   1, 5'd0,  32'h66,   0, 5'd0,  1,  0, 5'd0,  32'h0,    32'h0};
    tbl[7]  = '{0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    1, 5'd0,  0,  0, 5'd0,  32'h0,    32'h0};
    tbl[8]  = '{0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    0, 5'd0,  1,  0, 5'd0,  32'h0,    32'h0};
    tbl[9]  = '{0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    1, 5'd9,  1,  0, 5'd0,  32'h0,    32'h0000_0200};
    tbl[10] = '{0, 5'd0,  32'h0,    1, 5'd9,  32'h99,   1, 5'd9,  1,  1, 5'd9,  32'h99,   32'h0000_0200};
    tbl[11] = '{0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    0, 5'd0,  1,  0, 5'd0,  32'h0,    32'h0000_0200};
    tbl[12] = '{0, 5'd0,  32'h0,    1, 5'd9,  32'h77,   0, 5'd0,  1,  1, 5'd9,  32'h77,   32'h0};

    // reset state, observed while reset is held
    idle();
    #3;
    chk("rst_wr",    {63'd0, bus.writeRegMem}, 64'd0);
    chk("rst_rd",    {59'd0, bus.rd},          64'd0);
    chk("rst_data",  {32'd0, bus.dataIn},      64'd0);
    chk("rst_busy",  {32'd0, bus.busy},        64'd0);
    chk("rst_ready", {63'd0, bus.lsuReady},    64'd1);
    repeat (2) @(negedge clk);
    nReset = 1'b1;

    // table vectors
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].av, tbl[i].ard, tbl[i].ad, tbl[i].lv, tbl[i].lrd, tbl[i].ld, tbl[i].iv, tbl[i].ird);
      #1;
      chk($sformatf("tbl%0d_ready", i), {63'd0, bus.lsuReady}, {63'd0, tbl[i].rdy});
      @(negedge clk);
      chk($sformatf("tbl%0d_wr", i), {63'd0, bus.writeRegMem}, {63'd0, tbl[i].wr});
      if (tbl[i].wr) begin
        chk($sformatf("tbl%0d_rd", i),   {59'd0, bus.rd},     {59'd0, tbl[i].rd});
        chk($sformatf("tbl%0d_data", i), {32'd0, bus.dataIn}, {32'd0, tbl[i].d});
      end
      chk($sformatf("tbl%0d_busy", i), {32'd0, bus.busy}, {32'd0, tbl[i].busy});
    end
    idle();
    @(negedge clk);

    // starvation: skid holds x4 while the ALU writes four cycles running
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd4, 32'hC4, 1'b0, 5'd0);
    #1 chk("starv_ready0", {63'd0, bus.lsuReady}, 64'd1);
    @(negedge clk);
    chk("starv_rd_alu1", {59'd0, bus.rd}, 64'd1);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 5'(10 + k), 32'(k + 32'h100), 1'b1, 5'd6, 32'hC6, 1'b0, 5'd0);
      #1 chk($sformatf("starv%0d_ready", k), {63'd0, bus.lsuReady}, 64'd0);
      @(negedge clk);
      chk($sformatf("starv%0d_wr", k),   {63'd0, bus.writeRegMem}, 64'd1);
      chk($sformatf("starv%0d_rd", k),   {59'd0, bus.rd},          64'(10 + k));
      chk($sformatf("starv%0d_data", k), {32'd0, bus.dataIn},      64'(k + 32'h100));
    end
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'hC6, 1'b0, 5'd0);
    #1 chk("drain_ready", {63'd0, bus.lsuReady}, 64'd0);
    @(negedge clk);
    chk("drain_rd",   {59'd0, bus.rd},     64'd4);
    chk("drain_data", {32'd0, bus.dataIn}, 64'hC4);
    #1 chk("post_drain_ready", {63'd0, bus.lsuReady}, 64'd1);
    @(negedge clk);
    chk("x6_wr",   {63'd0, bus.writeRegMem}, 64'd1);
    chk("x6_rd",   {59'd0, bus.rd},          64'd6);
    chk("x6_data", {32'd0, bus.dataIn},      64'hC6);
    idle();
    @(negedge clk);

    // reset while the skid holds a colliding LSU result
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8);
    @(negedge clk);
    drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd8, 32'h88, 1'b0, 5'd0);
    @(negedge clk);
    idle();
    chk("mid_ready_low", {63'd0, bus.lsuReady},    64'd0);
    chk("mid_wr_high",   {63'd0, bus.writeRegMem}, 64'd1);
    #2 nReset = 1'b0;
    #1;
    chk("arst_wr",    {63'd0, bus.writeRegMem}, 64'd0);
    chk("arst_rd",    {59'd0, bus.rd},          64'd0);
    chk("arst_data",  {32'd0, bus.dataIn},      64'd0);
    chk("arst_busy",  {32'd0, bus.busy},        64'd0);
    chk("arst_ready", {63'd0, bus.lsuReady},    64'd1);
    @(negedge clk);
    nReset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d_wr", k), {63'd0, bus.writeRegMem}, 64'd0);
    end

    // random traffic against the queue model
    do_reset();
    mq.delete();
    m_busy = '0; m_wr = 1'b0; m_rd = '0; m_d = '0;
    lpend = 1'b0; lrd = '0; ld = '0;
    for (int c = 0; c < 400; c++) begin
      av = ($urandom_range(0, 99) < 45);
      ard = 5'($urandom_range(0, 31));
      ad = $urandom;
      if (!lpend && $urandom_range(0, 99) < 60) begin
        lpend = 1'b1;
        lrd = 5'($urandom_range(0, 31));
        ld = $urandom;
      end
      iv = ($urandom_range(0, 99) < 30);
      ird = 5'($urandom_range(0, 31));
      drive(av, ard, ad, lpend, lrd, ld, iv, ird);
      #1;
      mstep(av, ard, ad, lpend, lrd, ld, iv, ird, acc);
      if (acc) lpend = 1'b0;
      @(negedge clk);
      chk("rand_wr", {63'd0, bus.writeRegMem}, {63'd0, m_wr});
      if (m_wr) begin
        chk("rand_rd",   {59'd0, bus.rd},     {59'd0, m_rd});
        chk("rand_data", {32'd0, bus.dataIn}, {32'd0, m_d});
      end
      chk("rand_busy", {32'd0, bus.busy}, {32'd0, m_busy});
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
